sqrt_mantissa_core: RTL

Iterative modified non-restoring integer square-root engine for the floating-point square-root datapath. Consumes the aligned 106-bit radicand produced by the mantissa-to-binary conversion stage and produces the root mantissa (24 bits single, 53 bits double) plus a sticky bit for the downstream rounding stage. It retires one root bit per clock under a start/done handshake.

---
 rtl/sqrt_mantissa_core.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sqrt_mantissa_core.sv
// Iterative non-restoring square-root engine: one root bit per clock, start/done handshake.
// Optional abort input and logic are built only when SQRT_ABORT_EN is defined.
module sqrt_mantissa_core #(
    parameter int SIZE        = 106,
    parameter int ROOT_SIZE   = 53,
    parameter int FLOAT_ITER  = 24,
    parameter int DOUBLE_ITER = 53
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    input  logic                 isFloat,
    input  logic [SIZE-1:0]      radicand,
`ifdef SQRT_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [ROOT_SIZE-1:0] root,
    output logic                 sticky
);

    localparam int RW = ROOT_SIZE + 2;
    localparam int KW = $clog2(ROOT_SIZE);
    localparam logic [KW-1:0] K_FLOAT  = KW'(FLOAT_ITER - 1);
    localparam logic [KW-1:0] K_DOUBLE = KW'(DOUBLE_ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t                 r_state;
    logic [SIZE-1:0]        r_rad;
    logic [ROOT_SIZE-1:0]   r_q;
    logic [ROOT_SIZE-1:0]   r_root;
    logic [RW-1:0]          r_r;
    logic [KW-1:0]          r_k;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_sticky;

    logic [1:0]             w_pair;
    logic [RW-1:0]          w_r_shift;
    logic [RW-1:0]          w_q_term;
    logic [RW-1:0]          w_r_next;
    logic [RW-1:0]          w_r_fix;
    logic                   w_accept;

    // Pair k of the radicand; single precision never indexes above bit 47.
    assign w_pair    = r_rad[{r_k, 1'b0} +: 2];
    assign w_r_shift = {r_r[RW-3:0], w_pair};
    assign w_q_term  = r_r[RW-1] ? {r_q, 2'b11} : {r_q, 2'b01};
    assign w_r_next  = r_r[RW-1] ? (w_r_shift + w_q_term) : (w_r_shift - w_q_term);
    assign w_r_fix   = r_r[RW-1] ? (r_r + {1'b0, r_q, 1'b1}) : r_r;

`ifdef SQRT_ABORT_EN
    // An abort sampled together with start in DONE wins.
    assign w_accept = start && !(abort && (r_state == S_DONE));
`else
    assign w_accept = start;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= S_IDLE;
            r_rad    <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_k      <= '0;
            r_root   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_done <= 1'b0;
`ifdef SQRT_ABORT_EN
            if (abort && r_busy) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else
`endif
            begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (w_accept) begin
                            r_rad   <= radicand;
                            r_q     <= '0;
                            r_r     <= '0;
                            r_k     <= isFloat ? K_FLOAT : K_DOUBLE;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        r_r <= w_r_next;
                        r_q <= {r_q[ROOT_SIZE-2:0], ~w_r_next[RW-1]};
                        if (r_k == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_k <= r_k - 1'b1;
                        end
                    end
                    S_FIX: begin
                        r_r      <= w_r_fix;
                        r_root   <= r_q;
                        r_sticky <= |w_r_fix;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign root   = r_root;
    assign sticky = r_sticky;

endmodule
